// File: rtl/redmule_tile_walker_pkg.sv
// -----------------------------------------------------------------------------
// redmule_tile_walker_pkg
// Shared types and constants for the RedMulE tile walker:
//   - array geometry constants (ARRAY_HEIGHT, PIPE_REGS, ARRAY_WIDTH) and the
//     derived tile sizes TILE_K / TILE_N
//   - ctrl_regfile_t : the tiled register-file fields the walker consumes
//   - redmule_tile_t : one tile descriptor as handed to the streamer/scheduler
//   - walker_state_e : walker FSM states
//   - trim_extent()  : leftover trimming rule shared by all three dimensions
// -----------------------------------------------------------------------------
package redmule_tile_walker_pkg;

    localparam int unsigned ARRAY_HEIGHT = 4;
    localparam int unsigned PIPE_REGS    = 3;
    localparam int unsigned ARRAY_WIDTH  = 12;
    localparam int unsigned BITW         = 16;

    // One tile along K (and one chunk along N) covers the full pipelined depth.
    localparam int unsigned TILE_K = ARRAY_HEIGHT * (PIPE_REGS + 1);
    localparam int unsigned TILE_N = ARRAY_HEIGHT * (PIPE_REGS + 1);

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned ITER_W = 16;
    localparam int unsigned LFT_W  = 8;
    localparam int unsigned EXT_W  = 8;

    // Tiled configuration as produced by redmule_tiler. Iteration counts and
    // leftovers are already unpacked from their shared register words.
    typedef struct packed {
        logic [ADDR_W-1:0] x_addr;
        logic [ADDR_W-1:0] w_addr;
        logic [ADDR_W-1:0] z_addr;
        logic [ITER_W-1:0] x_rows_iter;    // MI
        logic [ITER_W-1:0] x_cols_iter;    // NI
        logic [ITER_W-1:0] w_cols_iter;    // KI
        logic [LFT_W-1:0]  x_rows_lftovr;
        logic [LFT_W-1:0]  x_cols_lftovr;
        logic [LFT_W-1:0]  w_cols_lftovr;
        logic [ADDR_W-1:0] x_rows_offs;    // bytes between X row blocks
        logic [ADDR_W-1:0] w_d0_stride;    // bytes between W rows
        logic [ADDR_W-1:0] z_d2_stride;    // bytes between Z row blocks
    } ctrl_regfile_t;

    typedef struct packed {
        logic [ADDR_W-1:0] x_addr;
        logic [ADDR_W-1:0] w_addr;
        logic [ADDR_W-1:0] z_addr;
        logic [EXT_W-1:0]  m_rows;
        logic [EXT_W-1:0]  k_cols;
        logic [EXT_W-1:0]  n_len;
        logic              first_n;
        logic              last_n;
        logic              last;
    } redmule_tile_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } walker_state_e;

    // The final tile of a dimension is trimmed to the leftover, unless the
    // dimension divides evenly (leftover of zero means "full tile").
    function automatic logic [EXT_W-1:0] trim_extent(
        input logic             is_last,
        input logic [LFT_W-1:0] lftovr,
        input logic [EXT_W-1:0] full
    );
        return (is_last && (lftovr != '0)) ? lftovr : full;
    endfunction

endpackage

// File: rtl/redmule_tile_walker_if.sv
// -----------------------------------------------------------------------------
// redmule_tile_walker_if
// Descriptor handshake between the tile walker and its consumer.
//   tile_o  : descriptor (walker -> consumer)
//   valid_o : descriptor valid (walker -> consumer)
//   ready_i : consumer accepts (consumer -> walker)
// Signal names are seen from the walker side.
// -----------------------------------------------------------------------------
interface redmule_tile_walker_if;
    import redmule_tile_walker_pkg::*;

    redmule_tile_t tile_o;
    logic          valid_o;
    logic          ready_i;

    modport master (output tile_o, output valid_o, input ready_i);
    modport slave  (input tile_o, input valid_o, output ready_i);

endinterface

// File: rtl/redmule_tile_counter.sv
// -----------------------------------------------------------------------------
// redmule_tile_counter
// One loop dimension of the tile walk: an index plus N_OFFS running byte
// offsets, each advanced by its own stride with a plain adder.
//   clk_i, rst_ni : clock, async active-low reset
//   iter          : number of iterations of this dimension
//   stride        : per-step increment of each offset lane
//   en            : step this dimension
//   clr           : synchronous clear of index and offsets (wins over en)
//   idx           : current index
//   offset        : current offset of each lane
//   last          : idx == iter-1
//   wrap          : stepping from the last index back to 0 (carry out)
// -----------------------------------------------------------------------------
module redmule_tile_counter #(
    parameter int unsigned IDX_W  = 16,
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned N_OFFS = 1
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic [IDX_W-1:0]              iter,
    input  logic [N_OFFS-1:0][ADDR_W-1:0] stride,
    input  logic                          en,
    input  logic                          clr,
    output logic [IDX_W-1:0]              idx,
    output logic [N_OFFS-1:0][ADDR_W-1:0] offset,
    output logic                          last,
    output logic                          wrap
);

    logic [IDX_W-1:0]              r_idx;
    logic [N_OFFS-1:0][ADDR_W-1:0] r_offset;

    assign last   = (r_idx == iter - IDX_W'(1));
    assign wrap   = en & last;
    assign idx    = r_idx;
    assign offset = r_offset;

    // NOTE: state is updated with non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_idx    <= '0;
            r_offset <= '0;
        end else if (clr) begin
            r_idx    <= '0;
            r_offset <= '0;
        end else if (en) begin
            if (last) begin
                r_idx    <= '0;
                r_offset <= '0;
            end else begin
                r_idx <= r_idx + IDX_W'(1);
                for (int i = 0; i < int'(N_OFFS); i++) begin
                    r_offset[i] <= r_offset[i] + stride[i];
                end
            end
        end
    end

endmodule

// File: rtl/redmule_tile_walker.sv
// -----------------------------------------------------------------------------
// redmule_tile_walker
// Walks the tiled GEMM iteration space (m outer, k middle, n inner) and emits
// one registered descriptor per tile over a valid/ready handshake.
//   clk_i, rst_ni : clock, async active-low reset
//   clear_i       : synchronous soft clear (drops any in-flight descriptor)
//   start_i       : start pulse, honoured only in IDLE
//   reg_file_i    : tiled configuration, captured into shadows at start
//   tile_if       : descriptor handshake (master side)
//   busy_o        : walker not in IDLE
//   done_o        : one-cycle pulse after the final handshake
//
// The three counters always point at the tile that will be loaded into the
// output register next. At start they sit at (0,0,0) and the first
// descriptor is built straight from reg_file_i, so it is valid one cycle
// after start; every load then steps the counters to the following tile.
// -----------------------------------------------------------------------------
module redmule_tile_walker
    import redmule_tile_walker_pkg::*;
#(
    parameter int unsigned ARRAY_WIDTH = redmule_tile_walker_pkg::ARRAY_WIDTH,
    parameter int unsigned TILE_K      = redmule_tile_walker_pkg::TILE_K,   // power of two
    parameter int unsigned TILE_N      = redmule_tile_walker_pkg::TILE_N,   // power of two
    parameter int unsigned BITW        = redmule_tile_walker_pkg::BITW
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         clear_i,
    input  logic                         start_i,
    input  ctrl_regfile_t                reg_file_i,
    redmule_tile_walker_if.master        tile_if,
    output logic                         busy_o,
    output logic                         done_o
);

    localparam int unsigned      N_SHIFT = $clog2(TILE_N);
    localparam logic [ADDR_W-1:0] N_STEP = ADDR_W'(TILE_N * BITW / 8);
    localparam logic [ADDR_W-1:0] K_STEP = ADDR_W'(TILE_K * BITW / 8);

    walker_state_e r_state;
    ctrl_regfile_t r_shadow;
    redmule_tile_t r_tile;
    logic          r_valid;
    logic          r_busy;
    logic          r_done;

    ctrl_regfile_t w_cfg;
    redmule_tile_t w_next_tile;
    logic          w_zero_iter;
    logic          w_launch;
    logic          w_hs;
    logic          w_advance;
    logic          w_load;
    logic          w_cnt_clr;

    // m lanes: [0] X row blocks, [1] Z row blocks
    // n lanes: [0] X column chunks, [1] W row chunks
    // k lane : [0] shared by W and Z columns
    logic [1:0][ADDR_W-1:0] w_m_stride, w_m_offset;
    logic [1:0][ADDR_W-1:0] w_n_stride, w_n_offset;
    logic [0:0][ADDR_W-1:0] w_k_stride, w_k_offset;
    logic                   w_m_last, w_k_last, w_n_last;
    logic                   w_k_wrap, w_n_wrap;
    logic [ITER_W-1:0]      w_n_idx;
    // m/k indices and the outermost carry are not needed by the descriptor.
    logic [ITER_W-1:0]      w_m_idx_unused, w_k_idx_unused;
    logic                   w_m_wrap_unused;

    // In IDLE the live register file feeds the first descriptor; afterwards
    // only the shadow copy is used, so later reg_file_i changes are ignored.
    assign w_cfg = (r_state == IDLE) ? reg_file_i : r_shadow;

    assign w_zero_iter = (reg_file_i.x_rows_iter == '0) |
                         (reg_file_i.x_cols_iter == '0) |
                         (reg_file_i.w_cols_iter == '0);

    assign w_launch  = (r_state == IDLE) & start_i & ~clear_i & ~w_zero_iter;
    assign w_hs      = r_valid & tile_if.ready_i;
    assign w_advance = (r_state == RUN) & w_hs & ~r_tile.last & ~clear_i;
    assign w_load    = w_launch | w_advance;
    assign w_cnt_clr = clear_i | (r_state == DONE);

    assign w_m_stride = {w_cfg.z_d2_stride, w_cfg.x_rows_offs};
    assign w_n_stride = {w_cfg.w_d0_stride << N_SHIFT, N_STEP};
    assign w_k_stride = K_STEP;

    redmule_tile_counter #(.IDX_W(ITER_W), .ADDR_W(ADDR_W), .N_OFFS(2)) u_n_cnt (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .iter   (w_cfg.x_cols_iter),
        .stride (w_n_stride),
        .en     (w_load),
        .clr    (w_cnt_clr),
        .idx    (w_n_idx),
        .offset (w_n_offset),
        .last   (w_n_last),
        .wrap   (w_n_wrap)
    );

    redmule_tile_counter #(.IDX_W(ITER_W), .ADDR_W(ADDR_W), .N_OFFS(1)) u_k_cnt (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .iter   (w_cfg.w_cols_iter),
        .stride (w_k_stride),
        .en     (w_n_wrap),
        .clr    (w_cnt_clr),
        .idx    (w_k_idx_unused),
        .offset (w_k_offset),
        .last   (w_k_last),
        .wrap   (w_k_wrap)
    );

    redmule_tile_counter #(.IDX_W(ITER_W), .ADDR_W(ADDR_W), .N_OFFS(2)) u_m_cnt (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .iter   (w_cfg.x_rows_iter),
        .stride (w_m_stride),
        .en     (w_k_wrap),
        .clr    (w_cnt_clr),
        .idx    (w_m_idx_unused),
        .offset (w_m_offset),
        .last   (w_m_last),
        .wrap   (w_m_wrap_unused)
    );

    // NOTE: every field gets a default first so no path through this block
    // leaves a variable unassigned, which would infer a latch.
    always_comb begin
        w_next_tile         = '0;
        w_next_tile.x_addr  = w_cfg.x_addr + w_m_offset[0] + w_n_offset[0];
        w_next_tile.w_addr  = w_cfg.w_addr + w_n_offset[1] + w_k_offset[0];
        w_next_tile.z_addr  = w_cfg.z_addr + w_m_offset[1] + w_k_offset[0];
        w_next_tile.m_rows  = trim_extent(w_m_last, w_cfg.x_rows_lftovr, EXT_W'(ARRAY_WIDTH));
        w_next_tile.k_cols  = trim_extent(w_k_last, w_cfg.w_cols_lftovr, EXT_W'(TILE_K));
        w_next_tile.n_len   = trim_extent(w_n_last, w_cfg.x_cols_lftovr, EXT_W'(TILE_N));
        w_next_tile.first_n = (w_n_idx == '0);
        w_next_tile.last_n  = w_n_last;
        w_next_tile.last    = w_n_last & w_k_last & w_m_last;
    end

    // NOTE: the shadow configuration is a handful of flops, not a memory, so
    // it is reset along with the rest of the state to give a known '0 map.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state  <= IDLE;
            r_shadow <= '0;
            r_tile   <= '0;
            r_valid  <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else if (clear_i) begin
            r_state  <= IDLE;
            r_shadow <= '0;
            r_tile   <= '0;
            r_valid  <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    r_done <= 1'b0;
                    if (start_i) begin
                        r_shadow <= reg_file_i;
                        r_busy   <= 1'b1;
                        if (w_zero_iter) begin
                            r_state <= DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= RUN;
                            r_valid <= 1'b1;
                            r_tile  <= w_next_tile;
                        end
                    end
                end
                RUN: begin
                    if (w_hs) begin
                        if (r_tile.last) begin
                            r_state <= DONE;
                            r_valid <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_tile <= w_next_tile;
                        end
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    r_valid <= 1'b0;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign tile_if.tile_o  = r_tile;
    assign tile_if.valid_o = r_valid;
    assign busy_o          = r_busy;
    assign done_o          = r_done;

endmodule

// File: tb/tb_redmule_tile_walker.sv
// -----------------------------------------------------------------------------
// tb_redmule_tile_walker
// Self-checking bench for redmule_tile_walker. Expected descriptors come from
// a nested-loop model of the GEMM walk built from M/N/K with plain arithmetic.
// -----------------------------------------------------------------------------
module tb_redmule_tile_walker;
    import redmule_tile_walker_pkg::*;

    localparam int unsigned AW = 12;
    localparam int unsigned TK = 16;
    localparam int unsigned TN = 16;
    localparam int unsigned BW = 16;

    logic          clk_i = 1'b0;
    logic          rst_ni;
    logic          clear_i;
    logic          start_i;
    ctrl_regfile_t reg_file_i;
    logic          busy_o;
    logic          done_o;

    redmule_tile_walker_if tile_if ();

    redmule_tile_walker #(
        .ARRAY_WIDTH (AW),
        .TILE_K      (TK),
        .TILE_N      (TN),
        .BITW        (BW)
    ) dut (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .clear_i    (clear_i),
        .start_i    (start_i),
        .reg_file_i (reg_file_i),
        .tile_if    (tile_if),
        .busy_o     (busy_o),
        .done_o     (done_o)
    );

    always #5 clk_i = ~clk_i;

    int            checks   = 0;
    int            failures = 0;
    redmule_tile_t exp_q[$];

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Tiled map for an M x N x K problem, as the tiler would produce it.
    function automatic ctrl_regfile_t make_cfg(input int m, input int n, input int k,
                                               input logic [31:0] xro,
                                               input logic [31:0] wd0,
                                               input logic [31:0] zd2);
        ctrl_regfile_t c;
        c.x_addr        = 32'h1000_0000;
        c.w_addr        = 32'h2000_0000;
        c.z_addr        = 32'h3000_0000;
        c.x_rows_iter   = 16'((m + AW - 1) / AW);
        c.x_rows_lftovr = 8'(m % AW);
        c.x_cols_iter   = 16'((n + TN - 1) / TN);
        c.x_cols_lftovr = 8'(n % TN);
        c.w_cols_iter   = 16'((k + TK - 1) / TK);
        c.w_cols_lftovr = 8'(k % TK);
        c.x_rows_offs   = xro;
        c.w_d0_stride   = wd0;
        c.z_d2_stride   = zd2;
        return c;
    endfunction

    function automatic ctrl_regfile_t scramble_cfg();
        ctrl_regfile_t c;
        c.x_addr        = $urandom;
        c.w_addr        = $urandom;
        c.z_addr        = $urandom;
        c.x_rows_iter   = 16'($urandom_range(1, 9));
        c.x_cols_iter   = 16'($urandom_range(1, 9));
        c.w_cols_iter   = 16'($urandom_range(1, 9));
        c.x_rows_lftovr = 8'($urandom_range(0, 11));
        c.x_cols_lftovr = 8'($urandom_range(0, 15));
        c.w_cols_lftovr = 8'($urandom_range(0, 15));
        c.x_rows_offs   = $urandom;
        c.w_d0_stride   = $urandom;
        c.z_d2_stride   = $urandom;
        return c;
    endfunction

    // Reference walk: m outer, k middle, n inner, addresses by multiplication.
    function automatic void build_model(input ctrl_regfile_t c);
        int mi_n = int'(c.x_rows_iter);
        int ni_n = int'(c.x_cols_iter);
        int ki_n = int'(c.w_cols_iter);
        redmule_tile_t d;
        exp_q.delete();
        for (int mi = 0; mi < mi_n; mi++) begin
            for (int ki = 0; ki < ki_n; ki++) begin
                for (int ni = 0; ni < ni_n; ni++) begin
                    d.x_addr  = c.x_addr + 32'(mi) * c.x_rows_offs + 32'(ni * TN * BW / 8);
                    d.w_addr  = c.w_addr + 32'(ni) * (32'(TN) * c.w_d0_stride) + 32'(ki * TK * BW / 8);
                    d.z_addr  = c.z_addr + 32'(mi) * c.z_d2_stride + 32'(ki * TK * BW / 8);
                    d.m_rows  = (mi == mi_n - 1 && c.x_rows_lftovr != 0) ? c.x_rows_lftovr : 8'(AW);
                    d.k_cols  = (ki == ki_n - 1 && c.w_cols_lftovr != 0) ? c.w_cols_lftovr : 8'(TK);
                    d.n_len   = (ni == ni_n - 1 && c.x_cols_lftovr != 0) ? c.x_cols_lftovr : 8'(TN);
                    d.first_n = (ni == 0);
                    d.last_n  = (ni == ni_n - 1);
                    d.last    = (ni == ni_n - 1) && (ki == ki_n - 1) && (mi == mi_n - 1);
                    exp_q.push_back(d);
                end
            end
        end
    endfunction

    task automatic check_idle_outputs(input string tag);
        check({tag, "_valid"}, 128'(tile_if.valid_o), 128'(0));
        check({tag, "_busy"},  128'(busy_o),          128'(0));
        check({tag, "_done"},  128'(done_o),          128'(0));
    endtask

    // Start one walk and consume it. clear_after >= 0 aborts with clear_i once
    // that many handshakes are done; poke_start re-pulses start_i mid-walk.
    task automatic run_walk(input ctrl_regfile_t c, input int ready_pct,
                            input int clear_after, input bit poke_start);
        int got = 0;
        int cyc = 0;
        bit hs;
        build_model(c);
        @(negedge clk_i);
        reg_file_i     = c;
        start_i        = 1'b1;
        tile_if.ready_i = 1'b0;
        @(negedge clk_i);
        start_i    = 1'b0;
        reg_file_i = scramble_cfg();
        while (got < exp_q.size()) begin
            if (cyc > 4000) begin
                check("walk_timeout", 128'(got), 128'(exp_q.size()));
                break;
            end
            check("run_valid", 128'(tile_if.valid_o), 128'(1));
            check("run_busy",  128'(busy_o),          128'(1));
            check("run_done",  128'(done_o),          128'(0));
            check($sformatf("tile[%0d]", got), 128'(tile_if.tile_o), 128'(exp_q[got]));
            if (got == clear_after) begin
                tile_if.ready_i = 1'b0;
                clear_i         = 1'b1;
                @(negedge clk_i);
                clear_i = 1'b0;
                check_idle_outputs("clear");
                return;
            end
            start_i = poke_start && (got == 1);
            hs = ($urandom_range(99) < ready_pct);
            tile_if.ready_i = hs;
            if (hs) got++;
            cyc++;
            @(negedge clk_i);
        end
        start_i         = 1'b0;
        tile_if.ready_i = 1'($urandom_range(1));
        check("end_valid", 128'(tile_if.valid_o), 128'(0));
        check("end_done",  128'(done_o),          128'(1));
        check("end_busy",  128'(busy_o),          128'(1));
        @(negedge clk_i);
        check_idle_outputs("after_done");
    endtask

    initial begin
        ctrl_regfile_t c;
        rst_ni          = 1'b0;
        clear_i         = 1'b0;
        start_i         = 1'b0;
        reg_file_i      = '0;
        tile_if.ready_i = 1'b0;

        // Reset state
        @(negedge clk_i);
        check_idle_outputs("reset");
        check("reset_tile", 128'(tile_if.tile_o), 128'(0));
        rst_ni = 1'b1;

        // Single tile: one descriptor at bases, full extents, done at t+2
        run_walk(make_cfg(12, 16, 16, 32'd384, 32'd32, 32'd384), 100, -1, 1'b0);

        // M leftover: second descriptor at +384 with one row
        run_walk(make_cfg(13, 16, 16, 32'd384, 32'd32, 32'd384), 100, -1, 1'b0);

        // N chunks with leftover 8
        run_walk(make_cfg(12, 40, 16, 32'd384, 32'd32, 32'd384), 100, -1, 1'b0);

        // K steps under 50% backpressure
        run_walk(make_cfg(12, 16, 40, 32'd384, 32'd32, 32'd384), 50, -1, 1'b0);

        // Zero iterations: done at t+1, no valid
        c = make_cfg(0, 16, 16, 32'd384, 32'd32, 32'd384);
        @(negedge clk_i);
        reg_file_i = c;
        start_i    = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        check("zero_done",  128'(done_o),          128'(1));
        check("zero_valid", 128'(tile_if.valid_o), 128'(0));
        check("zero_busy",  128'(busy_o),          128'(1));
        @(negedge clk_i);
        check_idle_outputs("zero_after");

        // start_i during RUN is ignored
        run_walk(make_cfg(24, 32, 32, 32'd768, 32'd64, 32'd512), 70, -1, 1'b1);

        // Clear after 5 of 12 handshakes, then a fresh walk from the origin
        c = make_cfg(24, 48, 32, 32'd384, 32'd32, 32'd384);
        run_walk(c, 100, 5, 1'b0);
        run_walk(c, 100, -1, 1'b0);

        // Randomised problems, strides and bases (addresses may wrap)
        for (int r = 0; r < 6; r++) begin
            c = make_cfg(int'($urandom_range(1, 50)), int'($urandom_range(1, 50)),
                         int'($urandom_range(1, 50)), $urandom, $urandom, $urandom);
            c.x_addr = $urandom;
            c.w_addr = $urandom;
            c.z_addr = $urandom;
            run_walk(c, 60, -1, 1'b0);
        end

        // Asynchronous reset mid-RUN
        @(negedge clk_i);
        reg_file_i      = make_cfg(36, 48, 48, 32'd384, 32'd32, 32'd384);
        start_i         = 1'b1;
        tile_if.ready_i = 1'b0;
        @(negedge clk_i);
        start_i = 1'b0;
        check("pre_rst_valid", 128'(tile_if.valid_o), 128'(1));
        #2 rst_ni = 1'b0;
        #1;
        check_idle_outputs("async_rst");
        check("async_rst_tile", 128'(tile_if.tile_o), 128'(0));
        @(negedge clk_i);
        rst_ni = 1'b1;

        // Recovery after reset
        run_walk(make_cfg(13, 40, 40, 32'd384, 32'd32, 32'd384), 80, -1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/redmule_tile_walker.md
# redmule_tile_walker

Reads the tiled configuration that `redmule_tiler` produces in the RedMulE register-file layout and walks the GEMM iteration space. For each tile it emits one descriptor over a valid/ready handshake. A descriptor carries the X, W and Z base addresses and the valid extents after leftover trimming. The block sits between the tiler output and the streamer/scheduler and replaces per-dimension address bookkeeping there.

## Interface
- `ARRAY_WIDTH`, default 12: Z rows per M-tile.
- `TILE_K`, default 16: K columns per tile, equal to ARRAY_HEIGHT*(PIPE_REGS+1). Must be a power of two.
- `TILE_N`, default 16: N elements per chunk. Must be a power of two.
- `BITW`, default 16: element width in bits.
- `clk_i`, in, 1: the only clock.
- `rst_ni`, in, 1: reset, asynchronous, active-low.
- `clear_i`, in, 1: synchronous soft clear.
- `start_i`, in, 1: single-cycle pulse. It is ignored unless the FSM is in IDLE.
- `reg_file_i`, in, `ctrl_regfile_t`: tiled map. The fields used are X/W/Z_ADDR, X_ITERS, W_ITERS, LEFTOVERS, X_ROWS_OFFS, W_D0_STRIDE and Z_D2_STRIDE. All strides are in bytes.
- `tile_o`, out, `redmule_tile_t`: the descriptor, with these fields:
  - `x_addr`, `w_addr`, `z_addr`: 32 bits each.
  - `m_rows`, `k_cols`, `n_len`: 8 bits each.
  - `first_n`, `last_n`, `last`: 1 bit each.
- `valid_o`, out, 1: descriptor valid.
- `ready_i`, in, 1: consumer accepts.
- `busy_o`, out, 1: high when the FSM is not in IDLE.
- `done_o`, out, 1: one-cycle pulse after the last handshake.

## Operation
- `start_i` in IDLE latches these values into shadow registers:
  - `x_rows_iter` (MI), `x_cols_iter` (NI), `w_cols_iter` (KI).
  - The four leftovers and the three strides.
  - The base addresses.
- Loop order is m outer, k middle, n inner. Indices are mi, ki and ni.
- Each dimension is handled by one counter instance that keeps:
  - an index,
  - a `last` flag (index == ITER-1),
  - a running address offset, advanced with adders only (no multipliers).
- Address rules:
  - x_addr = X_ADDR + mi*X_ROWS_OFFS + ni*(TILE_N*BITW/8).
  - w_addr = W_ADDR + ni*(TILE_N*W_D0_STRIDE) + ki*(TILE_K*BITW/8). The `TILE_N*` term is a left shift.
  - z_addr = Z_ADDR + mi*Z_D2_STRIDE + ki*(TILE_K*BITW/8).
  - All address arithmetic is 32-bit and wraps modulo 2^32.
- Extent rules:
  - m_rows = x_rows_lftovr when mi is last and that leftover is nonzero, otherwise ARRAY_WIDTH.
  - k_cols uses w_cols_lftovr/TILE_K in the same way.
  - n_len uses x_cols_lftovr/TILE_N in the same way.
- Flag rules:
  - first_n = (ni==0).
  - last_n = (ni==NI-1).
  - last = last_n & (ki==KI-1) & (mi==MI-1).
- FSM states are IDLE, RUN and DONE:
  - IDLE→RUN on `start_i` when MI, NI and KI are all nonzero.
  - IDLE→DONE on `start_i` when any of them is zero. No descriptor is emitted in that case.
  - RUN: `valid_o`=1. On each `valid_o & ready_i` the counters advance: ni wraps to 0 and carries into ki, and ki wraps to 0 and carries into mi.
  - RUN→DONE on a handshake where `last`=1.
  - DONE: `done_o`=1 for one cycle, then IDLE.
- Descriptor count is exactly MI*KI*NI. This equals TOT_X_READ.
- `clear_i` has priority over everything except reset:
  - It forces IDLE on the next edge and zeroes counters and shadows.
  - `valid_o`/`done_o` go low.
  - An in-flight descriptor is dropped.
- `start_i` during RUN or DONE is ignored. It is not queued.
- A change of `reg_file_i` after start has no effect, because the shadows hold the values.

## Timing
- Reset values: `valid_o`=0, `busy_o`=0, `done_o`=0, `tile_o`='0, FSM=IDLE.
- `start_i` at cycle t gives the first descriptor with `valid_o`=1 at t+1.
- Throughput is one descriptor per cycle while `ready_i`=1.
- `tile_o` is registered. It is held stable while `valid_o & ~ready_i`.
- `valid_o` never drops without a handshake, except under clear/reset.
- A final handshake at cycle c gives `valid_o`=0 and `done_o`=1 at c+1. `busy_o` stays 1 at c+1 and is 0 at c+2.
- Zero-iteration start at t gives `done_o`=1 at t+1 with no valid.
- `busy_o` is 1 from t+1 through the DONE cycle.
- Reset mid-RUN is asynchronous and returns all outputs to their reset values immediately.

## Structure
- `redmule_pkg` gains:
  - the `redmule_tile_t` typedef,
  - the `walker_state_e` enum (IDLE/RUN/DONE),
  - constants TILE_K and TILE_N, derived from ARRAY_HEIGHT and PIPE_REGS.
- One sub-module, `redmule_tile_counter`, instantiated three times. Its ports are:
  - inputs: iter, stride, `en`, `clr`;
  - outputs: idx, offset, `last`, `wrap`.

## Test plan
- M=12, N=16, K=16 (MI=NI=KI=1, leftovers 0), `ready_i`=1 → exactly one descriptor at t+1, with:
  - x/w/z_addr = bases,
  - m_rows=12, k_cols=16, n_len=16,
  - first_n=last_n=last=1,
  - `done_o` at t+2.
- M=13 (MI=2, x_rows_lftovr=1), N=16, K=16, X_ROWS_OFFS=384, Z_D2_STRIDE=384 → 2 descriptors. The second has x_addr=X_ADDR+384, z_addr=Z_ADDR+384, m_rows=1 and last=1.
- N=40 (NI=3, x_cols_lftovr=8), K=16, W_D0_STRIDE=32 → ni offsets of x_addr are +0, +32, +64. w_addr steps by 512. n_len is 16, 16, 8. first_n is set only on the first descriptor and last_n only on the third.
- K=40 with random `ready_i` backpressure at 50% → `tile_o` is stable while stalled. The sequence matches a golden loop model. There are 3 k-steps with k_cols=16, 16, 8.
- MI=0 → `done_o` at t+1 and no `valid_o`. A second `start_i` pulsed during RUN is ignored, and the descriptor count is unchanged.
- `clear_i` after 5 of 12 handshakes → `valid_o`=0 and `busy_o`=0 next cycle. A new `start_i` restarts the walk from mi=ki=ni=0.
